adder_seq_ctrl: RTL and testbench
=================================

Name: adder_seq_ctrl

Overview:
Multi-precision add/subtract sequencer. It reuses one internal N-bit `adder` slice (parameter N) to add two WORDS*N-bit operands, one N-bit slice per clock, LSB slice first. The slice carry is chained through a register between cycles. The block sits between an operand producer and a result consumer, with a valid/ready handshake on each side.

Parameters:
N, 4, width of the internal adder slice in bits (N >= 1)
WORDS, 4, number of slices per operation (WORDS >= 1); operand width W = N*WORDS

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operand request valid
start_ready  output  1  block can accept a request
op_a  input  W  operand A
op_b  input  W  operand B
cin  input  1  carry-in for add mode; ignored when sub=1
sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1)
res_valid  output  1  result valid
res_ready  input  1  consumer accepts result
result  output  W  sum/difference
cout  output  1  carry out of MSB slice; in sub mode, 1 = no borrow
overflow  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset: rst_n low clears everything immediately, regardless of clk.
  - result=0, cout=0, overflow=0, res_valid=0, busy=0.
  - FSM=IDLE, slice index=0, carry register=0, operand registers=0.
  - start_ready=1 while in IDLE, including directly after reset release.
  - Reset mid-operation aborts the operation. No partial result is ever flagged valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On a rising edge with start_valid=1, the request is accepted:
    - register A=op_a.
    - register Beff = sub ? ~op_b : op_b.
    - carry register = sub ? 1 : cin.
    - index=0; result cleared to 0; go to RUN.
  - Operands may change freely after acceptance.
- RUN (one slice per cycle):
  - The adder is fed A[idx*N +: N], Beff[idx*N +: N] and the carry register.
  - Each edge: result[idx*N +: N] <= Sum; carry register <= Cout.
  - If idx == WORDS-1: cout <= Cout; overflow <= (A_msb == Beff_msb) && (Sum_msb != A_msb); go to DONE.
  - Otherwise idx <= idx+1.
  - start_ready=0.
- DONE:
  - res_valid=1, start_ready=0.
  - result, cout and overflow are held stable until res_ready=1 is sampled on a rising edge.
  - On that edge: res_valid <= 0, go to IDLE.
  - result, cout and overflow keep their values until the next acceptance.
  - A start_valid in the same cycle as the DONE→IDLE edge is not accepted; it can be accepted on the following edge at the earliest.
- Latency: acceptance edge E0, then RUN edges E1..E_WORDS. res_valid rises after edge E_WORDS, i.e. it is high in the WORDS-th cycle after acceptance.
- Throughput: at most one operation per WORDS+2 cycles.
- Widths: the index counter is max(1, $clog2(WORDS)) bits. All arithmetic is modulo 2^W; the carry beyond W appears only on cout.
- WORDS=1: RUN lasts a single cycle and behaves as an N-bit registered adder.
- start_valid and sub are sampled only in IDLE. Any input change during RUN/DONE has no effect.
- res_ready is ignored outside DONE.

Test Plan:
1. Reset: hold rst_n=0, toggle inputs, release → result=0, cout=0, overflow=0, res_valid=0, busy=0, start_ready=1. Assert rst_n asynchronously between edges → outputs clear without waiting for a clock edge.
2. N=4, WORDS=4, add: op_a=0x00FF, op_b=0x0001, cin=0, res_ready=1 → res_valid high exactly 4 cycles after acceptance; result=0x0100, cout=0, overflow=0. Repeat with cin=1 → result=0x0101.
3. Carry/overflow: 0xFFFF+0x0001 → 0x0000, cout=1, overflow=0. 0x7FFF+0x0001 → 0x8000, cout=0, overflow=1.
4. Subtract: 0x0005-0x0007 → 0xFFFE, cout=0, overflow=0. 0x8000-0x0001 → 0x7FFF, cout=1, overflow=1. Verify that cin=1 is ignored in sub mode.
5. Backpressure: hold res_ready=0 for 3 cycles in DONE while start_valid=1 with new operands → result, cout and overflow stable, start_ready=0, no new acceptance. Raise res_ready → IDLE next cycle; new request accepted one edge later. Verify correct back-to-back results.
6. Reset mid-operation: assert rst_n during RUN at idx=2 → all outputs 0, res_valid never pulses. After release, 0x1234+0x4321 → 0x5555, cout=0, overflow=0.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: multi-precision add/subtract sequencer reusing one N-bit adder slice
module adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + (N+1)'(ci);
endmodule

module adder_seq_ctrl #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [N*WORDS-1:0] op_a,
  input  logic [N*WORDS-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N*WORDS-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);
  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic          cout_q, cout_d, ovf_q, ovf_d;
  logic [N-1:0]  a_s, b_s, sum;
  logic          co, last;

  assign a_s  = a_q[idx_q*N +: N];
  assign b_s  = b_q[idx_q*N +: N];
  assign last = idx_q == IW'(WORDS - 1);

  adder #(.N(N)) u_adder (.a(a_s), .b(b_s), .ci(carry_q), .s(sum), .co(co));

  assign start_ready = state_q == IDLE;
  assign res_valid   = state_q == DONE;
  assign busy        = state_q != IDLE;
  assign result      = result_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;

  // Next state: capture operands in IDLE, process one slice per RUN cycle, hand off in DONE
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    if (state_q == IDLE && start_valid) begin
      a_d      = op_a;
      b_d      = sub ? ~op_b : op_b;
      carry_d  = sub ? 1'b1 : cin;
      idx_d    = '0;
      result_d = '0;
      state_d  = RUN;
    end else if (state_q == RUN) begin
      result_d[idx_q*N +: N] = sum;
      carry_d = co;
      if (last) begin
        cout_d  = co;
        ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum[N-1] != a_q[W-1]);
        state_d = DONE;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (state_q == DONE && res_ready) begin
      state_d = IDLE;
    end
  end

  // State and datapath registers, cleared asynchronously so a reset aborts any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed self-checking bench for the multi-precision sequencer
module tb_adder_seq_ctrl;
  localparam int N = 4, WORDS = 4, W = 16;

  logic clk = 1'b0, rst_n = 1'b0, start_valid = 1'b0, cin = 1'b0, sub = 1'b0, res_ready = 1'b1;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic start_ready, res_valid, cout, overflow, busy;
  logic [W-1:0] result;
  int n_cmp = 0, n_bad = 0;

  adder_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .cout(cout), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, " result"}, result, 16'h0);
    chk({tag, " cout"}, cout, 1'b0);
    chk({tag, " overflow"}, overflow, 1'b0);
    chk({tag, " res_valid"}, res_valid, 1'b0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " start_ready"}, start_ready, 1'b1);
  endtask

  // Called at the negedge right after the acceptance edge
  task automatic wait_result(input string tag, input logic [W-1:0] er, input logic ec, input logic eo);
    for (int i = 1; i <= WORDS; i++) begin
      @(negedge clk);
      chk({tag, " res_valid timing"}, res_valid, (i == WORDS) ? 1'b1 : 1'b0);
      chk({tag, " busy"}, busy, 1'b1);
    end
    chk({tag, " result"}, result, er);
    chk({tag, " cout"}, cout, ec);
    chk({tag, " overflow"}, overflow, eo);
    chk({tag, " start_ready in DONE"}, start_ready, 1'b0);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s,
                       input logic [W-1:0] er, input logic ec, input logic eo);
    @(negedge clk);
    chk({tag, " start_ready"}, start_ready, 1'b1);
    op_a = a; op_b = b; cin = c; sub = s; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0; op_a = ~a; op_b = ~b; cin = ~c; sub = ~s;
    wait_result(tag, er, ec, eo);
    res_ready = 1'b1;
    @(negedge clk);
    chk({tag, " res_valid after ack"}, res_valid, 1'b0);
    chk({tag, " start_ready after ack"}, start_ready, 1'b1);
    chk({tag, " result held"}, result, er);
  endtask

  initial begin
    // Reset held while inputs toggle
    repeat (3) begin
      @(negedge clk);
      start_valid = ~start_valid; op_a = op_a + 16'h1357; op_b = ~op_b; cin = ~cin; sub = ~sub;
    end
    chk_clear("in_reset");
    start_valid = 1'b0; cin = 1'b0; sub = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_clear("after_reset");

    do_op("add_ff_1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_op("add_ff_1_cin", 16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
    do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("sub_cin_ignored", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Backpressure: result held in DONE, no new acceptance while start_valid is high
    res_ready = 1'b0;
    @(negedge clk);
    op_a = 16'h0102; op_b = 16'h0304; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    wait_result("bp_first", 16'h0406, 1'b0, 1'b0);
    op_a = 16'h1111; op_b = 16'h2222; start_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp hold result", result, 16'h0406);
      chk("bp hold cout", cout, 1'b0);
      chk("bp hold overflow", overflow, 1'b0);
      chk("bp hold res_valid", res_valid, 1'b1);
      chk("bp hold start_ready", start_ready, 1'b0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp idle start_ready", start_ready, 1'b1);
    chk("bp idle busy", busy, 1'b0);
    chk("bp idle res_valid", res_valid, 1'b0);
    chk("bp idle result", result, 16'h0406);
    @(negedge clk);
    chk("bp second accepted", busy, 1'b1);
    start_valid = 1'b0;
    wait_result("bp_second", 16'h3333, 1'b0, 1'b0);
    @(negedge clk);

    // Asynchronous reset between edges while holding a result in DONE
    res_ready = 1'b0;
    op_a = 16'h7FFF; op_b = 16'h0001; cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    wait_result("pre_async", 16'h8000, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_clear("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;

    // Reset in RUN at idx=2
    @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'h0001; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun busy", busy, 1'b1);
    rst_n = 1'b0;
    #1 chk_clear("midrun_reset");
    repeat (2) begin
      @(negedge clk);
      chk("midrun in reset res_valid", res_valid, 1'b0);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post reset res_valid", res_valid, 1'b0);
      chk("post reset busy", busy, 1'b0);
    end
    do_op("after_midrun", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
